// File: rtl/std_fifo_pkg.sv
// std_fifo_pkg: constants shared by std_fifo and std_fifo_reader.
package std_fifo_pkg;
    localparam int WIDTH_DEFAULT = 8;
    localparam int READER_DEPTH = 3;
    function automatic logic [1:0] inc_mod3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/std_fifo_reader_if.sv
// std_fifo_reader_if: std_fifo pop/q side plus valid/ready stream side of the reader.
interface std_fifo_reader_if import std_fifo_pkg::*; #(parameter int WIDTH = WIDTH_DEFAULT);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_q;
    logic             fifo_pop;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;
    modport master (
        input  fifo_empty, fifo_q, out_ready,
        output fifo_pop, out_valid, out_data, occupancy
    );
    modport slave (
        output fifo_empty, fifo_q, out_ready,
        input  fifo_pop, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/std_fifo_reader_buf.sv
// std_fifo_reader_buf: 3-entry register queue with mod-3 head/tail pointers and a count.
module std_fifo_reader_buf import std_fifo_pkg::*; #(parameter int WIDTH = WIDTH_DEFAULT) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem_q [READER_DEPTH];
    logic [WIDTH-1:0] mem_d [READER_DEPTH];
    logic [1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    always_comb begin
        mem_d = mem_q;
        tail_d = push ? inc_mod3(tail_q) : tail_q;
        head_d = pop ? inc_mod3(head_q) : head_q;
        if (push) mem_d[tail_q] = push_data;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end
    assign head_data = mem_q[head_q];
    assign count = count_q;
endmodule

// File: rtl/std_fifo_reader.sv
// std_fifo_reader: turns the 1-cycle-latency std_fifo pop/q port into a valid/ready stream.
module std_fifo_reader import std_fifo_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = READER_DEPTH
) (
    input logic clk,
    input logic rst,
    std_fifo_reader_if.master bus
);
    logic inflight_q, inflight_d, xfer;
    logic [1:0] occ;
    logic [WIDTH-1:0] head;
    assign xfer = bus.out_valid && bus.out_ready;
    // credit counts the word still in flight, so out_ready never reaches fifo_pop
    always_comb begin
        bus.fifo_pop = rst && !bus.fifo_empty && (({1'b0, occ} + {2'b0, inflight_q}) < 3'(DEPTH));
        inflight_d = bus.fifo_pop;
        bus.out_valid = occ != 2'd0;
        bus.out_data = head;
        bus.occupancy = occ;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight_q <= 1'b0;
        else inflight_q <= inflight_d;
    end
    std_fifo_reader_buf #(.WIDTH(WIDTH)) u_buf (
        .clk(clk),
        .rst(rst),
        .push(inflight_q),
        .push_data(bus.fifo_q),
        .pop(xfer),
        .head_data(head),
        .count(occ)
    );
endmodule

// File: tb/tb_std_fifo_reader.sv
// tb_std_fifo_reader: randomized and directed stimulus against a queue-based std_fifo and stream model.
module tb_std_fifo_reader;
    localparam int W = 8;
    logic clk = 0;
    logic rst = 0;
    int total = 0;
    int bad = 0;
    int rx = 0;
    logic [W-1:0] fq [$];
    logic [W-1:0] exp_q [$];
    std_fifo_reader_if #(.WIDTH(W)) bus();
    std_fifo_reader #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask
    // std_fifo model: one-cycle read latency, shares the reader's reset
    always @(posedge clk or negedge rst) begin
        if (!rst) bus.fifo_q <= '0;
        else if (bus.fifo_pop) begin
            bus.fifo_q <= fq.pop_front();
            bus.fifo_empty <= (fq.size() == 0);
        end
    end
    // occupancy = words popped and already landed, minus words delivered
    int pops, xfers, occ_exp;
    logic last_pop, prev_hold;
    logic [W-1:0] held;
    always @(negedge clk) begin
        if (!rst) begin
            pops = 0;
            xfers = 0;
            last_pop = 0;
            prev_hold = 0;
        end else begin
            occ_exp = pops - int'(last_pop) - xfers;
            chk("occupancy", 32'(bus.occupancy), occ_exp);
            chk("out_valid", 32'(bus.out_valid), 32'(occ_exp != 0));
            chk("fifo_pop", 32'(bus.fifo_pop), 32'(!bus.fifo_empty && (occ_exp + int'(last_pop) < 3)));
            if (last_pop && occ_exp >= 3 && !(bus.out_valid && bus.out_ready)) chk("overflow", 32'(occ_exp), 2);
            if (prev_hold) chk("stable", 32'(bus.out_data), 32'(held));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 32'(bus.out_data), 32'hFFFF_FFFF);
                else chk("data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                rx++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            pops += int'(bus.fifo_pop);
            xfers += int'(bus.out_valid && bus.out_ready);
            last_pop = bus.fifo_pop;
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [W-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask
    task automatic flush();
        fq.delete();
        exp_q.delete();
        bus.fifo_empty = 1'b1;
    endtask
    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.occupancy != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
    endtask
    initial begin
        int n, r0;
        bus.out_ready = 0;
        bus.fifo_empty = 1;
        flush();
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        repeat (5) begin
            @(negedge clk);
            chk("rst_pop", 32'(bus.fifo_pop), 0);
            chk("rst_valid", 32'(bus.out_valid), 0);
            chk("rst_occ", 32'(bus.occupancy), 0);
            chk("rst_data", 32'(bus.out_data), 0);
        end
        tick(1);
        rst = 1;
        #1;
        chk("first_pop", 32'(bus.fifo_pop), 1);
        bus.out_ready = 1;
        drain(50);
        tick(3);
        bus.out_ready = 0;
        push(8'h5A);
        @(negedge clk);
        chk("lat_pop", 32'(bus.fifo_pop), 1);
        chk("lat_v0", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat_v1", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat_v2", 32'(bus.out_valid), 1);
        chk("lat_data", 32'(bus.out_data), 32'h5A);
        bus.out_ready = 1;
        drain(20);
        tick(2);
        r0 = rx;
        for (int i = 1; i <= 64; i++) push(8'(i));
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.fifo_pop) n++;
            else if (n > 0) break;
        end
        chk("pop_run", 32'(n), 64);
        drain(20);
        chk("rx_64", 32'(rx - r0), 64);
        tick(1);
        bus.out_ready = 0;
        for (int i = 1; i <= 10; i++) push(8'(i));
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += int'(bus.fifo_pop);
        end
        chk("stall_pops", 32'(n), 3);
        chk("stall_occ", 32'(bus.occupancy), 3);
        chk("stall_data", 32'(bus.out_data), 1);
        tick(1);
        r0 = rx;
        bus.out_ready = 1;
        drain(40);
        chk("rx_10", 32'(rx - r0), 10);
        tick(1);
        r0 = rx;
        for (int i = 1; i <= 64; i++) push(8'(i));
        for (int i = 0; i < 400 && (exp_q.size() != 0 || bus.occupancy != 0); i++) begin
            bus.out_ready = ~bus.out_ready;
            tick(1);
        end
        chk("alt_rx", 32'(rx - r0), 64);
        r0 = rx;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                push(8'($urandom_range(0, 255)));
                n++;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        bus.out_ready = 1;
        drain(1000);
        chk("rand_rx", 32'(rx - r0), 32'(n));
        tick(1);
        bus.out_ready = 0;
        for (int i = 1; i <= 6; i++) push(8'(i));
        tick(8);
        chk("pre_rst_occ", 32'(bus.occupancy), 3);
        rst = 0;
        flush();
        #1;
        chk("arst_occ", 32'(bus.occupancy), 0);
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_pop", 32'(bus.fifo_pop), 0);
        chk("arst_data", 32'(bus.out_data), 0);
        tick(2);
        rst = 1;
        r0 = rx;
        bus.out_ready = 1;
        for (int i = 1; i <= 4; i++) push(8'(i));
        drain(20);
        chk("post_rst_rx", 32'(rx - r0), 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
